// File: rtl/axi4lite_regfile.sv
// AXI4-Lite slave register file with a configurable data width, address width and register count.
// Supports byte-lane writes, AW/W accepted in either order, SLVERR on illegal access, and read-only status registers.
module axi4lite_regfile #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 6,
   parameter int                    NUM_REGS   = 16,
   parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic                           s_axi_aclk,
   input  logic                           s_axi_areset,
   input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
   input  logic                           s_axi_awvalid,
   output logic                           s_axi_awready,
   input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
   input  logic                           s_axi_wvalid,
   output logic                           s_axi_wready,
   output logic [1:0]                     s_axi_bresp,
   output logic                           s_axi_bvalid,
   input  logic                           s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
   input  logic                           s_axi_arvalid,
   output logic                           s_axi_arready,
   output logic [DATA_WIDTH-1:0]          s_axi_rdata,
   output logic [1:0]                     s_axi_rresp,
   output logic                           s_axi_rvalid,
   input  logic                           s_axi_rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
   localparam int IDX_WIDTH  = ADDR_WIDTH - ADDR_LSB;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t              w_state_reg;
   logic                  aw_held_reg;
   logic                  w_held_reg;
   logic [IDX_WIDTH-1:0]  aw_idx_reg;
   logic [DATA_WIDTH-1:0] wdata_reg;
   logic [STRB_WIDTH-1:0] wstrb_reg;
   logic                  awready_reg;
   logic                  wready_reg;
   logic                  bvalid_reg;
   logic [1:0]            bresp_reg;

   r_state_t              r_state_reg;
   logic                  arready_reg;
   logic                  rvalid_reg;
   logic [DATA_WIDTH-1:0] rdata_reg;
   logic [1:0]            rresp_reg;

   logic                  aw_hs;
   logic                  w_hs;
   logic                  ar_hs;
   logic                  commit;
   logic                  w_legal;
   logic [IDX_WIDTH-1:0]  ar_idx;
   logic [NUM_REGS-1:0]   w_hit;
   logic [NUM_REGS-1:0]   r_hit;
   logic [DATA_WIDTH-1:0] rd_val [NUM_REGS];
   logic [DATA_WIDTH-1:0] r_mux;
   logic                  unused_sink;

   assign aw_hs  = s_axi_awvalid && awready_reg;
   assign w_hs   = s_axi_wvalid && wready_reg;
   assign ar_hs  = s_axi_arvalid && arready_reg;
   assign ar_idx = s_axi_araddr[ADDR_WIDTH-1:ADDR_LSB];
   assign commit = (w_state_reg == W_IDLE) && aw_held_reg && w_held_reg;
   // A write is legal only if it hits an in-range register that is not read-only.
   assign w_legal = |(w_hit & ~RO_MASK);

   // Status inputs of writable registers and the sub-word address bits carry no meaning here.
   assign unused_sink = &{1'b0, reg_in, s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi = gi + 1) begin : g_reg
         assign w_hit[gi] = (aw_idx_reg == IDX_WIDTH'(gi));
         assign r_hit[gi] = (ar_idx == IDX_WIDTH'(gi));
         if (RO_MASK[gi]) begin : g_ro
            assign rd_val[gi] = reg_in[gi*DATA_WIDTH +: DATA_WIDTH];
            assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = RESET_VAL;
         end else begin : g_rw
            logic [DATA_WIDTH-1:0] value_reg;
            always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
               if (s_axi_areset) begin
                  value_reg <= RESET_VAL;
               end else if (commit && w_hit[gi]) begin
                  for (int b = 0; b < STRB_WIDTH; b++) begin
                     if (wstrb_reg[b]) begin
                        value_reg[8*b +: 8] <= wdata_reg[8*b +: 8];
                     end
                  end
               end
            end
            assign rd_val[gi] = value_reg;
            assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = value_reg;
         end
      end
   endgenerate

   // One-hot select; an out-of-range index hits nothing and yields zero.
   always_comb begin
      r_mux = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (r_hit[i]) begin
            r_mux = r_mux | rd_val[i];
         end
      end
   end

   always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         w_state_reg <= W_IDLE;
         aw_held_reg <= 1'b0;
         w_held_reg  <= 1'b0;
         aw_idx_reg  <= '0;
         wdata_reg   <= '0;
         wstrb_reg   <= '0;
         awready_reg <= 1'b0;
         wready_reg  <= 1'b0;
         bvalid_reg  <= 1'b0;
         bresp_reg   <= RESP_OKAY;
      end else begin
         case (w_state_reg)
            W_IDLE: begin
               if (commit) begin
                  aw_held_reg <= 1'b0;
                  w_held_reg  <= 1'b0;
                  bvalid_reg  <= 1'b1;
                  bresp_reg   <= w_legal ? RESP_OKAY : RESP_SLVERR;
                  w_state_reg <= W_RESP;
               end else begin
                  if (aw_hs) begin
                     aw_held_reg <= 1'b1;
                     aw_idx_reg  <= s_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB];
                     awready_reg <= 1'b0;
                  end else if (!aw_held_reg) begin
                     awready_reg <= 1'b1;
                  end
                  if (w_hs) begin
                     w_held_reg <= 1'b1;
                     wdata_reg  <= s_axi_wdata;
                     wstrb_reg  <= s_axi_wstrb;
                     wready_reg <= 1'b0;
                  end else if (!w_held_reg) begin
                     wready_reg <= 1'b1;
                  end
               end
            end
            W_RESP: begin
               if (s_axi_bready) begin
                  bvalid_reg  <= 1'b0;
                  awready_reg <= 1'b1;
                  wready_reg  <= 1'b1;
                  w_state_reg <= W_IDLE;
               end
            end
            default: w_state_reg <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         r_state_reg <= R_IDLE;
         arready_reg <= 1'b0;
         rvalid_reg  <= 1'b0;
         rdata_reg   <= '0;
         rresp_reg   <= RESP_OKAY;
      end else begin
         case (r_state_reg)
            R_IDLE: begin
               if (ar_hs) begin
                  arready_reg <= 1'b0;
                  rvalid_reg  <= 1'b1;
                  rdata_reg   <= r_mux;
                  rresp_reg   <= (|r_hit) ? RESP_OKAY : RESP_SLVERR;
                  r_state_reg <= R_DATA;
               end else begin
                  arready_reg <= 1'b1;
               end
            end
            R_DATA: begin
               if (s_axi_rready) begin
                  rvalid_reg  <= 1'b0;
                  arready_reg <= 1'b1;
                  r_state_reg <= R_IDLE;
               end
            end
            default: r_state_reg <= R_IDLE;
         endcase
      end
   end

   assign s_axi_awready = awready_reg;
   assign s_axi_wready  = wready_reg;
   assign s_axi_bvalid  = bvalid_reg;
   assign s_axi_bresp   = bresp_reg;
   assign s_axi_arready = arready_reg;
   assign s_axi_rvalid  = rvalid_reg;
   assign s_axi_rdata   = rdata_reg;
   assign s_axi_rresp   = rresp_reg;

endmodule
